// File: rtl/move_seq_packer.sv
// move_seq_packer
//    Packs single 4-bit move codes into a MAX_MOVES-slot sequence bus. The
//    bus is handed to the consumer with a valid/taken handshake. The first
//    accepted move ends up in the highest occupied slot, and the newest move
//    sits in [3:0].
//
// Optional feature macro: MOVE_CANCEL_EN
//    When defined, a move that is the inverse of the newest slot (same face
//    bits [3:1], different bit 0) pops that slot instead of appending.
//
// Ports
//    clock_25mhz  in   system clock
//    reset        in   synchronous, active-high
//    move_in      in   [3:0] move code, legal 2..13
//    move_valid   in   move_in offered this cycle
//    move_ready   out  packer accepts a move this cycle
//    flush        in   close the current sequence and present it
//    seq_out      out  [4*MAX_MOVES-1:0] packed sequence, unused slots zero
//    num_moves    out  [7:0] number of valid slots
//    seq_valid    out  seq_out/num_moves complete and stable
//    seq_taken    in   single-cycle acknowledge from the consumer
//    bad_move     out  one-cycle pulse: illegal code offered and dropped
//    overflow     out  sticky: move_valid seen while move_ready was low
//
// state   | meaning
// --------+----------------------------------------------------
// COLLECT | accepting moves; flush or a full buffer presents
// PRESENT | sequence held on the bus until seq_taken

module move_seq_packer #(
   parameter int MAX_MOVES = 50
) (
   input  logic                   clock_25mhz,
   input  logic                   reset,
   input  logic [3:0]             move_in,
   input  logic                   move_valid,
   output logic                   move_ready,
   input  logic                   flush,
   output logic [4*MAX_MOVES-1:0] seq_out,
   output logic [7:0]             num_moves,
   output logic                   seq_valid,
   input  logic                   seq_taken,
   output logic                   bad_move,
   output logic                   overflow
);

   localparam int W = 4 * MAX_MOVES;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [W-1:0]     seq_next;
   logic [7:0]       count_next;
   logic             bad_next;
   logic             ovf_next;
   logic             legal;
   logic             cancel;

   assign legal = (move_in >= 4'd2) && (move_in <= 4'd13);

`ifdef MOVE_CANCEL_EN
   // Inverse of the newest slot: same face, opposite direction bit.
   assign cancel = (num_moves != 8'd0) &&
                   (move_in[3:1] == seq_out[3:1]) &&
                   (move_in[0] != seq_out[0]);
`else
   assign cancel = 1'b0;
`endif

   always_ff @(posedge clock_25mhz) begin
      if (reset) begin
         state     <= COLLECT;
         seq_out   <= '0;
         num_moves <= 8'd0;
         bad_move  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_next;
         seq_out   <= seq_next;
         num_moves <= count_next;
         bad_move  <= bad_next;
         overflow  <= ovf_next;
      end
   end

   always_comb begin
      state_next = state;
      seq_next   = seq_out;
      count_next = num_moves;
      bad_next   = 1'b0;
      ovf_next   = overflow;

      case (state)
         COLLECT: begin
            if (move_valid) begin
               if (!legal) begin
                  bad_next = 1'b1;
               end else if (cancel) begin
                  seq_next   = seq_out >> 4;
                  count_next = num_moves - 8'd1;
               end else begin
                  seq_next   = {seq_out[W-5:0], move_in};
                  count_next = num_moves + 8'd1;
               end
            end
            // Both conditions look at the count after this cycle's move.
            if ((flush && count_next != 8'd0) || count_next == 8'(MAX_MOVES))
               state_next = PRESENT;
         end
         PRESENT: begin
            if (move_valid)
               ovf_next = 1'b1;
            if (seq_taken) begin
               seq_next   = '0;
               count_next = 8'd0;
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   assign move_ready = (state == COLLECT);
   assign seq_valid  = (state == PRESENT);

endmodule
